// File: rtl/fpu_operand_loader_pkg.sv
// Shared types and constants for the FPU operand loader.
package fpu_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        HOLD
    } state_t;

    typedef logic [2:0] opcode_t;

    localparam logic [3:0] HDR_SYNC_DEFAULT = 4'hA;

    // Low bit of the sync nibble inside a header byte.
    localparam int HDR_SYNC_LSB = 4;

    // A header is good when its sync nibble matches; bit 3 is ignored.
    function automatic logic hdr_match(input logic [7:0] hdr, input logic [3:0] sync);
        return hdr[HDR_SYNC_LSB +: 4] == sync;
    endfunction

endpackage

// File: rtl/fpu_operand_loader_if.sv
// Byte-in / frame-out handshake bundle of the operand loader.
interface fpu_operand_loader_if
    import fpu_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 32
);
    logic                  byte_valid;
    logic [7:0]            data_in;
    logic                  abort;
    logic                  out_ready;
    logic                  out_valid;
    logic [WORD_WIDTH-1:0] op_a;
    logic [WORD_WIDTH-1:0] op_b;
    opcode_t               opcode;

    // Loader side.
    modport slave (
        input  byte_valid, data_in, abort, out_ready,
        output out_valid, op_a, op_b, opcode
    );

    // Byte source / FPU core side.
    modport master (
        output byte_valid, data_in, abort, out_ready,
        input  out_valid, op_a, op_b, opcode
    );
endinterface

// File: rtl/fpu_operand_loader_operand_shift_reg.sv
// Operand assembly register: bytes enter at the LSB, so MSB-first input
// ends up in natural order once the word is full.
module operand_shift_reg #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  shift_en,
    input  logic [7:0]            data_in,
    output logic [WORD_WIDTH-1:0] word
);

    // Shift one byte in per enabled cycle; otherwise hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word <= '0;
        end else if (shift_en) begin
            word <= {word[WORD_WIDTH-9:0], data_in};
        end
    end

endmodule

// File: rtl/fpu_operand_loader.sv
// Byte-serial operand framer: header byte, then operand A and operand B,
// each MSB byte first, presented to the FPU core over valid/ready.
module fpu_operand_loader
    import fpu_loader_pkg::*;
#(
    parameter int         WORD_WIDTH = 32,
    parameter logic [3:0] HDR_SYNC   = HDR_SYNC_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    fpu_operand_loader_if.slave  bus,
    output logic                 busy,
    output logic                 frame_error,
    output logic                 overrun
);

    localparam int N     = WORD_WIDTH / 8;
    localparam int CNT_W = $clog2(N);

    state_t             state;
    logic [CNT_W-1:0]   byte_cnt;
    opcode_t            opcode_q;
    logic               out_valid_q;
    logic               shift_a;
    logic               shift_b;
    logic               cnt_last;
    logic               hdr_good;

    // Bytes only reach the operand registers in their load phase; abort wins.
    always_comb begin
        shift_a  = !bus.abort && bus.byte_valid && (state == LOAD_A);
        shift_b  = !bus.abort && bus.byte_valid && (state == LOAD_B);
        cnt_last = (byte_cnt == CNT_W'(N - 1));
        hdr_good = hdr_match(bus.data_in, HDR_SYNC);
    end

    operand_shift_reg #(.WORD_WIDTH(WORD_WIDTH)) u_op_a (
        .clock    (clock),
        .reset_n  (reset_n),
        .shift_en (shift_a),
        .data_in  (bus.data_in),
        .word     (bus.op_a)
    );

    operand_shift_reg #(.WORD_WIDTH(WORD_WIDTH)) u_op_b (
        .clock    (clock),
        .reset_n  (reset_n),
        .shift_en (shift_b),
        .data_in  (bus.data_in),
        .word     (bus.op_b)
    );

    // Frame FSM with registered flags; a header arriving on the accepting
    // HOLD cycle is decoded immediately so back-to-back frames lose nothing.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            opcode_q    <= '0;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (bus.abort) begin
                state       <= IDLE;
                byte_cnt    <= '0;
                out_valid_q <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.byte_valid) begin
                            if (hdr_good) begin
                                opcode_q <= bus.data_in[2:0];
                                byte_cnt <= '0;
                                state    <= LOAD_A;
                                busy     <= 1'b1;
                            end else begin
                                frame_error <= 1'b1;
                            end
                        end
                    end
                    LOAD_A: begin
                        if (bus.byte_valid) begin
                            if (cnt_last) begin
                                byte_cnt <= '0;
                                state    <= LOAD_B;
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end
                    LOAD_B: begin
                        if (bus.byte_valid) begin
                            if (cnt_last) begin
                                byte_cnt    <= '0;
                                state       <= HOLD;
                                out_valid_q <= 1'b1;
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (bus.out_ready) begin
                            out_valid_q <= 1'b0;
                            if (bus.byte_valid && hdr_good) begin
                                opcode_q <= bus.data_in[2:0];
                                byte_cnt <= '0;
                                state    <= LOAD_A;
                            end else begin
                                state       <= IDLE;
                                busy        <= 1'b0;
                                frame_error <= bus.byte_valid;
                            end
                        end else if (bus.byte_valid) begin
                            overrun <= 1'b1;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        byte_cnt    <= '0;
                        out_valid_q <= 1'b0;
                        busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.opcode    = opcode_q;

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Bench for fpu_operand_loader: directed frames from the test plan, then
// random traffic, all compared against a frame-level reference model.
module tb_fpu_operand_loader;

    localparam int W = 32;
    localparam int N = W / 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    fpu_operand_loader_if #(.WORD_WIDTH(W)) bus ();
    logic busy, frame_error, overrun;

    fpu_operand_loader #(.WORD_WIDTH(W), .HDR_SYNC(4'hA)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .busy        (busy),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a frame is "collecting" bytes into a queue or "held"
    // waiting for the consumer; operands are computed arithmetically.
    bit           m_collect, m_held, m_ovr, m_ferr;
    logic [2:0]   m_opc;
    logic [7:0]   m_q[$];
    logic [W-1:0] m_a, m_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_collect = 0; m_held = 0; m_ovr = 0; m_ferr = 0;
        m_opc = '0; m_a = '0; m_b = '0;
        m_q.delete();
    endtask

    task automatic model_header(input logic [7:0] d);
        if (d[7:4] == 4'hA) begin
            m_collect = 1;
            m_opc = d[2:0];
            m_q.delete();
        end else begin
            m_ferr = 1;
        end
    endtask

    task automatic model_step();
        logic [W-1:0] a, b;
        m_ferr = 0;
        if (bus.abort) begin
            m_collect = 0;
            m_held = 0;
            m_q.delete();
        end else if (m_held) begin
            if (bus.out_ready) begin
                m_held = 0;
                if (bus.byte_valid) model_header(bus.data_in);
            end else if (bus.byte_valid) begin
                m_ovr = 1;
            end
        end else if (m_collect) begin
            if (bus.byte_valid) begin
                m_q.push_back(bus.data_in);
                if (m_q.size() == 2 * N) begin
                    a = '0; b = '0;
                    for (int i = 0; i < N; i++) begin
                        a = a + (W'(m_q[i])     << (8 * (N - 1 - i)));
                        b = b + (W'(m_q[N + i]) << (8 * (N - 1 - i)));
                    end
                    m_a = a; m_b = b;
                    m_collect = 0;
                    m_held = 1;
                end
            end
        end else if (bus.byte_valid) begin
            model_header(bus.data_in);
        end
    endtask

    task automatic check_outs();
        chk("out_valid",   64'(bus.out_valid), 64'(m_held));
        chk("busy",        64'(busy),          64'(m_collect | m_held));
        chk("frame_error", 64'(frame_error),   64'(m_ferr));
        chk("overrun",     64'(overrun),       64'(m_ovr));
        chk("opcode",      64'(bus.opcode),    64'(m_opc));
        if (m_held) begin
            chk("op_a", 64'(bus.op_a), 64'(m_a));
            chk("op_b", 64'(bus.op_b), 64'(m_b));
        end
    endtask

    task automatic cyc(input logic bv, input logic [7:0] d, input logic ab, input logic rdy);
        bus.byte_valid = bv;
        bus.data_in    = d;
        bus.abort      = ab;
        bus.out_ready  = rdy;
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outs();
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic rdy);
        cyc(1'b1, hdr, 1'b0, rdy);
        for (int i = N - 1; i >= 0; i--) cyc(1'b1, a[8*i +: 8], 1'b0, rdy);
        for (int i = N - 1; i >= 0; i--) cyc(1'b1, b[8*i +: 8], 1'b0, rdy);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"},   64'(bus.out_valid), 64'd0);
        chk({tag, "_op_a"},    64'(bus.op_a),      64'd0);
        chk({tag, "_op_b"},    64'(bus.op_b),      64'd0);
        chk({tag, "_opcode"},  64'(bus.opcode),    64'd0);
        chk({tag, "_busy"},    64'(busy),          64'd0);
        chk({tag, "_ferr"},    64'(frame_error),   64'd0);
        chk({tag, "_overrun"}, 64'(overrun),       64'd0);
    endtask

    initial begin
        logic [7:0] d;
        bus.byte_valid = 0; bus.data_in = '0; bus.abort = 0; bus.out_ready = 0;
        model_reset();
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Nominal frame, consumer always ready.
        send_frame(8'hA1, 32'h3F80_0000, 32'h4000_0000, 1'b1);
        chk("nom_op_a", 64'(bus.op_a), 64'h3F80_0000);
        chk("nom_op_b", 64'(bus.op_b), 64'h4000_0000);
        chk("nom_opcode", 64'(bus.opcode), 64'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("nom_valid_one_cycle", 64'(bus.out_valid), 64'd0);

        // Bad header then a good frame.
        cyc(1'b1, 8'h51, 1'b0, 1'b1);
        chk("bad_hdr_pulse", 64'(frame_error), 64'd1);
        send_frame(8'hA2, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        chk("hdr2_opcode", 64'(bus.opcode), 64'd2);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure with two dropped bytes.
        send_frame(8'hA4, 32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("bp_op_a", 64'(bus.op_a), 64'hCAFE_F00D);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("bp_valid_drop", 64'(bus.out_valid), 64'd0);
        chk("bp_overrun_sticky", 64'(overrun), 64'd1);

        // Back-to-back: header accepted in the same cycle as the prior frame.
        send_frame(8'hA5, 32'h0102_0304, 32'h0506_0708, 1'b1);
        send_frame(8'hA3, 32'hA0B0_C0D0, 32'hE0F0_0011, 1'b1);
        chk("b2b_opcode", 64'(bus.opcode), 64'd3);
        chk("b2b_op_a", 64'(bus.op_a), 64'hA0B0_C0D0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Abort after three A bytes.
        cyc(1'b1, 8'hA6, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h77, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("abort_busy", 64'(busy), 64'd0);
        send_frame(8'hA7, 32'h5555_AAAA, 32'h0F0F_F0F0, 1'b1);
        chk("abort_op_a", 64'(bus.op_a), 64'h5555_AAAA);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset during LOAD_B.
        cyc(1'b1, 8'hA0, 1'b0, 1'b1);
        for (int i = 0; i < N + 2; i++) cyc(1'b1, 8'h5A, 1'b0, 1'b1);
        bus.byte_valid = 0;
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        send_frame(8'hA6, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1);
        chk("post_rst_op_b", 64'(bus.op_b), 64'h0000_0001);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d[7:4] = 4'hA;
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 60) == 0,
                $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_operand_loader.md
# fpu_operand_loader

Byte-serial operand framer that sits directly downstream of the FPU input synchronizer. It consumes the synchronized byte stream and recognises a header byte carrying the opcode. It then assembles two WORD_WIDTH-bit operands, MSB byte first, and presents {opcode, op_a, op_b} to the FPU core over a valid/ready handshake.

## Interface
- WORD_WIDTH, default 32: operand width in bits; must be a multiple of 8 and at least 16.
- HDR_SYNC, default 4'hA: required value of header bits [7:4].
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- byte_valid  input  1  data_in carries a new byte this cycle (one byte per high cycle).
- data_in  input  8  synchronized byte from the input synchronizer.
- abort  input  1  synchronous: discard any partial frame and return to IDLE.
- out_ready  input  1  FPU core accepts the frame this cycle.
- out_valid  output  1  op_a, op_b and opcode are valid.
- op_a  output  WORD_WIDTH  first operand.
- op_b  output  WORD_WIDTH  second operand.
- opcode  output  3  header bits [2:0].
- busy  output  1  a frame is in progress or held (state != IDLE).
- frame_error  output  1  one-cycle pulse: header rejected.
- overrun  output  1  sticky: a byte arrived while a frame was held and not accepted.

## Operation
- Frame: 1 header byte, then N = WORD_WIDTH/8 bytes of A, then N bytes of B; each operand is sent MSB byte first.
- Header bits [7:4] must equal HDR_SYNC. Bit 3 is reserved and ignored. Bits [2:0] give the opcode.
- **IDLE:** on byte_valid with a good header, latch the opcode, clear byte_cnt and go to LOAD_A. With a bad header, stay in IDLE and pulse frame_error on the next cycle.
- **LOAD_A:** on each byte_valid, shift the byte into A from the LSB side (A <= {A[W-9:0], byte}) and increment byte_cnt. When the byte that completes A (byte_cnt == N-1) is taken, clear byte_cnt and go to LOAD_B.
- **LOAD_B:** same as LOAD_A, but into B. The final byte goes to HOLD.
- **HOLD:** out_valid = 1. When out_ready = 1, the transfer completes:
  - with byte_valid = 0, go to IDLE;
  - with byte_valid = 1, the byte is processed as a header in that same cycle (no bubble), so the next state is LOAD_A or IDLE plus frame_error.
- **HOLD, out_ready = 0:** when byte_valid = 1, drop the byte, set overrun and stay in HOLD.
- abort has priority over all other inputs. It forces IDLE and deasserts out_valid on the next edge. It does not clear overrun and does not pulse frame_error.
- overrun clears only on reset.
- op_a, op_b and opcode hold their values, stable, from out_valid rise until acceptance. After acceptance they keep their last values.

## Timing
- Reset values: out_valid 0, op_a 0, op_b 0, opcode 0, busy 0, frame_error 0, overrun 0, state IDLE, byte_cnt 0.
- out_valid rises on the edge that samples the last B byte, i.e. it is visible in the cycle after that byte's byte_valid.
- Minimum frame period is 2N+1 cycles with back-to-back bytes and out_ready tied high.
- byte_valid gaps of any length are allowed between bytes; the partial frame holds. There is no timeout.
- reset_n asserted mid-frame clears everything immediately, asynchronously; the partial frame is lost.
- busy is registered: it rises the cycle after a good header is sampled and falls the cycle after acceptance (or abort) that returns to IDLE.

## Structure
- Shared package fpu_loader_pkg holds:
  - the state enum {IDLE, LOAD_A, LOAD_B, HOLD};
  - the HDR_SYNC default;
  - an opcode typedef (3 bits);
  - a header field position constant.
- One sub-module, operand_shift_reg (parameter WORD_WIDTH; ports clock, reset_n, shift_en, data_in[7:0], word), instantiated twice, for A and B.
- FSM, byte counter (width $clog2(N)), opcode register and flags live in the top module.

## Test plan
- Nominal: header A1, A = 3F 80 00 00, B = 40 00 00 00, out_ready = 1 -> op_a = 32'h3F800000, op_b = 32'h40000000, opcode = 1, out_valid for exactly one cycle, beginning the cycle after the 9th byte.
- Bad header 51, then a valid frame headed A2 -> frame_error pulses once after 51; the second frame is assembled normally with opcode = 2.
- Backpressure: frame completes with out_ready = 0 for 5 cycles while 2 extra bytes arrive -> outputs stable, overrun = 1 and stays 1, out_valid drops one cycle after out_ready rises.
- Back-to-back: header A3 sampled in the same cycle out_ready accepts the prior frame -> no lost byte; the new frame loads with opcode = 3.
- abort after 3 A bytes, then a full frame -> first frame discarded, second frame correct, frame_error never asserted.
- reset_n pulsed low mid-LOAD_B -> all outputs read 0 immediately; a subsequent frame decodes correctly.
